// File: rtl/mod_ram_arbiter.sv
// mod_ram_arbiter: two-port arbiter in front of a synchronous single-port RAM.
// Port 0 (CPU) and port 1 (loader/DMA) compete for one RAM access per cycle.
// Grants are combinational; the winning command is registered onto the RAM
// strobe the following cycle, and read data is returned to the originating
// port as a one-cycle rvalid pulse two cycles after acceptance.
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 always win
// simultaneous requests (no round-robin pointer is built in that case).
module mod_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // RAM command stage (cycle after acceptance)
  logic              cmd_en_q, cmd_en_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  port_e             cmd_port_q, cmd_port_d;

  // Read pending while the RAM produces data
  logic              rd_pend_q, rd_pend_d;
  port_e             rd_port_q, rd_port_d;

  // Read return registers per port
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

`ifndef ARB_FIXED_PRIORITY_EN
  port_e ptr_q, ptr_d;

  // Round-robin pointer: after any acceptance, favour the other port next time.
  always_comb begin
    ptr_d = ptr_q;
    if (m0_gnt)      ptr_d = PORT1;
    else if (m1_gnt) ptr_d = PORT0;
  end

  // Pointer register; reset favours port 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= PORT0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Grant decode; reset low forces both grants off immediately.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
`ifdef ARB_FIXED_PRIORITY_EN
      m0_gnt = m0_req;
      m1_gnt = m1_req & ~m0_req;
`else
      if (m0_req && m1_req) begin
        m0_gnt = (ptr_q == PORT0);
        m1_gnt = (ptr_q == PORT1);
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
`endif
    end
  end

  // Next-state for the command, read-pending and read-return stages.
  always_comb begin
    cmd_en_d    = m0_gnt | m1_gnt;
    cmd_we_d    = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_port_d  = cmd_port_q;
    if (m1_gnt) begin
      cmd_we_d    = m1_we;
      cmd_addr_d  = m1_addr;
      cmd_wdata_d = m1_wdata;
      cmd_port_d  = PORT1;
    end else if (m0_gnt) begin
      cmd_we_d    = m0_we;
      cmd_addr_d  = m0_addr;
      cmd_wdata_d = m0_wdata;
      cmd_port_d  = PORT0;
    end

    rd_pend_d = cmd_en_q & ~cmd_we_q;
    rd_port_d = cmd_port_q;

    rvalid0_d = rd_pend_q & (rd_port_q == PORT0);
    rvalid1_d = rd_pend_q & (rd_port_q == PORT1);
    rdata0_d  = rvalid0_d ? ram_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? ram_rdata : rdata1_q;
  end

  // Pipeline registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: data registers are reset too, because the outputs they drive must read 0 in reset.
      cmd_en_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q  <= PORT0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= PORT0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      cmd_en_q    <= cmd_en_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_port_q  <= cmd_port_d;
      rd_pend_q   <= rd_pend_d;
      rd_port_q   <= rd_port_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ram_en    = cmd_en_q;
  assign ram_we    = cmd_we_q;
  assign ram_addr  = cmd_addr_q;
  assign ram_wdata = cmd_wdata_q;
  assign m0_rvalid = rvalid0_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rvalid = rvalid1_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mod_ram_arbiter.sv
// Bench for mod_ram_arbiter: directed vectors with a behavioural RAM, a
// scoreboard of expected RAM commands and read returns, and a monitor that
// checks them whenever the DUT presents ram_en or an rvalid.
module tb_mod_ram_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         due;
  } cmd_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  cmd_t       cmd_q[$];
  rd_t        rd0_q[$];
  rd_t        rd1_q[$];
  logic [7:0] ref_mem [256];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  mod_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous single-port RAM, cleared at time zero.
  initial begin : ram_model
    logic [7:0] mem [256];
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    ram_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record an accepted access: expected RAM command next cycle, read data 3 counts later.
  task automatic accept(input logic we, input logic [7:0] a, input logic [7:0] d, input bit port);
    cmd_t c;
    rd_t  r;
    c.we = we; c.addr = a; c.wdata = d; c.due = cyc + 1;
    cmd_q.push_back(c);
    if (we) ref_mem[a] = d;
    else begin
      r.data = ref_mem[a];
      r.due  = cyc + 3;
      if (port) rd1_q.push_back(r);
      else      rd0_q.push_back(r);
    end
  endtask

  // Drive one cycle of requests after the falling edge and check the grants.
  task automatic cycle(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                       input logic eg0, input logic eg1, input string tag);
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    check({tag, " m0_gnt"}, m0_gnt, eg0);
    check({tag, " m1_gnt"}, m1_gnt, eg1);
    if (eg0) accept(w0, a0, d0, 1'b0);
    if (eg1) accept(w1, a1, d1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Monitor: compares DUT output events against the scoreboard queues.
  initial begin : monitor
    cmd_t c;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        if (cmd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ram_cmd: unexpected ram_en addr 0x%0h, expected none", ram_addr);
        end else begin
          c = cmd_q.pop_front();
          check("ram_we", ram_we, c.we);
          check("ram_addr", ram_addr, c.addr);
          if (c.we) check("ram_wdata", ram_wdata, c.wdata);
          check("ram_cmd_cycle", cyc, c.due);
        end
      end else begin
        check("ram_we_idle", ram_we, 1'b0);
        if (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
          c = cmd_q.pop_front();
          tests++; fails++;
          $display("FAIL ram_cmd: ram_en low, expected command to 0x%0h", c.addr);
        end
      end

      if (m0_rvalid) begin
        if (rd0_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL m0_rvalid: unexpected pulse data 0x%0h, expected none", m0_rdata);
        end else begin
          r = rd0_q.pop_front();
          check("m0_rdata", m0_rdata, r.data);
          check("m0_rvalid_cycle", cyc, r.due);
        end
      end else if (rd0_q.size() > 0 && rd0_q[0].due <= cyc) begin
        r = rd0_q.pop_front();
        tests++; fails++;
        $display("FAIL m0_rvalid: low, expected pulse with data 0x%0h", r.data);
      end

      if (m1_rvalid) begin
        if (rd1_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL m1_rvalid: unexpected pulse data 0x%0h, expected none", m1_rdata);
        end else begin
          r = rd1_q.pop_front();
          check("m1_rdata", m1_rdata, r.data);
          check("m1_rvalid_cycle", cyc, r.due);
        end
      end else if (rd1_q.size() > 0 && rd1_q[0].due <= cyc) begin
        r = rd1_q.pop_front();
        tests++; fails++;
        $display("FAIL m1_rvalid: low, expected pulse with data 0x%0h", r.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " m0_gnt"},    m0_gnt,    1'b0);
    check({tag, " m1_gnt"},    m1_gnt,    1'b0);
    check({tag, " ram_en"},    ram_en,    1'b0);
    check({tag, " ram_we"},    ram_we,    1'b0);
    check({tag, " ram_addr"},  ram_addr,  8'h00);
    check({tag, " ram_wdata"}, ram_wdata, 8'h00);
    check({tag, " m0_rvalid"}, m0_rvalid, 1'b0);
    check({tag, " m1_rvalid"}, m1_rvalid, 1'b0);
    check({tag, " m0_rdata"},  m0_rdata,  8'h00);
    check({tag, " m1_rdata"},  m1_rdata,  8'h00);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    m0_req = 1; m1_req = 1;
    #1;
    check_reset_outputs("por");
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    reset = 1'b1;

    // Port 0 write then read-back of the same address.
    cycle(1, 1, 8'h10, 8'h5A, 0, 0, 0, 0, 1, 0, "wr0");
    cycle(1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 1, 0, "rd0");
    idle(3);
    check("rd0 value", m0_rdata, 8'h5A);
    idle(2);
    check("rd0 hold", m0_rdata, 8'h5A);

    // Port 1 writes 0x33 to 0x00 while port 0 reads 0x00.
`ifdef ARB_FIXED_PRIORITY_EN
    cycle(1, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h33, 1, 0, "raw_a");
    cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h33, 0, 1, "raw_b");
    idle(4);
    check("raw value", m0_rdata, 8'h00);
`else
    cycle(1, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h33, 0, 1, "raw_a");
    cycle(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, "raw_b");
    idle(4);
    check("raw value", m0_rdata, 8'h33);
`endif

    // Reset one cycle after a port 0 read is accepted.
    cycle(1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 1, 0, "rd_rst");
    @(negedge clk);
    #2;
    reset = 1'b0;
    m0_req = 1; m1_req = 1;
    rd0_q.delete();
    rd1_q.delete();
    cmd_q.delete();
    #1;
    check_reset_outputs("mid");
    repeat (3) @(negedge clk);
    check("mid m0_rvalid late", m0_rvalid, 1'b0);
    m0_req = 0; m1_req = 0;
    reset = 1'b1;

    // Both ports read every cycle; first grant after reset goes to port 0.
    for (int i = 0; i < 8; i++)
      cycle(1, 0, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00,
`ifdef ARB_FIXED_PRIORITY_EN
            1'b1, 1'b0,
`else
            (i % 2 == 0), (i % 2 == 1),
`endif
            "both");
    cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, "m1_alone");
    idle(4);
    check("both m0 value", m0_rdata, 8'h5A);
    check("both m1 value", m1_rdata, 8'h33);

    // Port 1 raises then drops a write while port 0 is being granted.
    cycle(1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'hEE, 1, 0, "drop_a");
    cycle(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, "drop_b");
    cycle(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, "drop_c");
    idle(4);
    check("drop m0 value", m0_rdata, 8'h5A);

    // Drain: every expected event must have been seen.
    idle(4);
    check("drain cmd_q", cmd_q.size(), 0);
    check("drain rd0_q", rd0_q.size(), 0);
    check("drain rd1_q", rd1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
